// File: rtl/oled_serial_receiver.sv
// oled_serial_receiver: LSB-first serial frame capture into a valid/ready FIFO
// Optional saturating overflow counter output enabled by OLED_RX_OVF_CNT_EN.
module oled_serial_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  sclk,
  input  logic                  rst_n,
  input  logic                  mosi,
  input  logic                  cs,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic                  frame_err,
  output logic                  overflow,
  output logic                  busy
`ifdef OLED_RX_OVF_CNT_EN
  ,
  output logic [7:0]            ovf_count
`endif
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] ERR = 2'd2;
  logic [1:0] state, state_nxt;
  logic [CW-1:0] count;
  logic [DATA_WIDTH-1:0] shifter, word;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic last, pop, full, empty, wr;
  always_comb begin
    word = {mosi, shifter[DATA_WIDTH-1:1]};
    last = !cs && count == CW'(DATA_WIDTH - 1);
    empty = wptr == rptr;
    full = (wptr ^ rptr) == {1'b1, {AW{1'b0}}};
    rdata_valid = !empty;
    pop = rdata_valid && rdata_ready;
    wr = last && (!full || pop);
    rdata = empty ? '0 : mem[rptr[AW-1:0]];
    busy = rst_n && (!cs || count != '0);
    frame_err = state == ERR;
    state_nxt = !cs ? SHIFT : (count != '0) ? ERR : IDLE;
  end
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      shifter <= '0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      overflow <= last && full && !pop;
      if (!cs) begin
        shifter <= word;
        count <= last ? '0 : count + CW'(1);
      end else count <= '0;
      if (wr) wptr <= wptr + (AW + 1)'(1);
      if (pop) rptr <= rptr + (AW + 1)'(1);
    end
  // storage needs no reset: rdata is masked while the FIFO is empty
  always_ff @(posedge sclk)
    if (wr) mem[wptr[AW-1:0]] <= word;
`ifdef OLED_RX_OVF_CNT_EN
  always_ff @(posedge sclk or negedge rst_n)
    if (!rst_n) ovf_count <= '0;
    else if (overflow && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
`endif
endmodule

// File: tb/tb_oled_serial_receiver.sv
// tb_oled_serial_receiver: directed checks of framing, FIFO order, frame errors and overflow
module tb_oled_serial_receiver;
  logic sclk = 1'b0, rst_n = 1'b0, mosi = 1'b0, cs = 1'b1, rdata_ready = 1'b0;
  logic [7:0] rdata;
  logic rdata_valid, frame_err, overflow, busy;
  int checks = 0, errors = 0;
`ifdef OLED_RX_OVF_CNT_EN
  logic [7:0] ovf_count;
`endif
  oled_serial_receiver dut (
    .sclk(sclk), .rst_n(rst_n), .mosi(mosi), .cs(cs),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready),
    .frame_err(frame_err), .overflow(overflow), .busy(busy)
`ifdef OLED_RX_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );
  always #5 sclk = ~sclk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic c, input logic d);
    cs = c;
    mosi = d;
    @(negedge sclk);
  endtask
  task automatic send(input logic [7:0] v);
    for (int i = 0; i < 8; i++) step(1'b0, v[i]);
  endtask
  initial begin
    @(negedge sclk);
    @(negedge sclk);
    chk("rst_rdata", rdata, 0);
    chk("rst_valid", rdata_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    // 1: single frame
    send(8'hA5);
    chk("t1_rdata", rdata, 8'hA5);
    chk("t1_valid", rdata_valid, 1);
    chk("t1_busy", busy, 1);
    rdata_ready = 1'b1;
    step(1'b1, 1'b0);
    chk("t1_popped", rdata_valid, 0);
    chk("t1_idle", busy, 0);
    // 2: back-to-back frames
    send(8'h3C);
    chk("t2_w0", rdata, 8'h3C);
    chk("t2_v0", rdata_valid, 1);
    send(8'hC3);
    chk("t2_w1", rdata, 8'hC3);
    chk("t2_v1", rdata_valid, 1);
    chk("t2_ferr", frame_err, 0);
    step(1'b1, 1'b0);
    chk("t2_empty", rdata_valid, 0);
    chk("t2_ferr2", frame_err, 0);
    // 3: aborted frame
    rdata_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    chk("t3_busy_mid", busy, 1);
    step(1'b1, 1'b0);
    chk("t3_ferr", frame_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_empty", rdata_valid, 0);
    step(1'b1, 1'b0);
    chk("t3_ferr_end", frame_err, 0);
    send(8'h81);
    chk("t3_rdata", rdata, 8'h81);
    chk("t3_valid", rdata_valid, 1);
    chk("t3_ferr_after", frame_err, 0);
    rdata_ready = 1'b1;
    step(1'b1, 1'b0);
    chk("t3_drained", rdata_valid, 0);
    // 4: overflow
    rdata_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(8'(k));
    chk("t4_ovf_pre", overflow, 0);
    chk("t4_head", rdata, 8'h01);
    send(8'h05);
    chk("t4_ovf", overflow, 1);
    chk("t4_head2", rdata, 8'h01);
    step(1'b1, 1'b0);
    chk("t4_ovf_end", overflow, 0);
`ifdef OLED_RX_OVF_CNT_EN
    chk("t4_ovf_count", ovf_count, 1);
`endif
    // 5: push on full coincides with pop
    for (int i = 0; i < 7; i++) step(1'b0, i == 0 || i == 2);
    rdata_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("t5_ovf", overflow, 0);
    cs = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk("t5_drain_valid", rdata_valid, 1);
      chk("t5_drain", rdata, 32'(k));
      step(1'b1, 1'b0);
    end
    chk("t5_empty", rdata_valid, 0);
`ifdef OLED_RX_OVF_CNT_EN
    chk("t5_ovf_count", ovf_count, 1);
`endif
    // 6: asynchronous reset mid-frame
    rdata_ready = 1'b0;
    send(8'h11);
    send(8'h22);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    chk("t6_pre_valid", rdata_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rdata", rdata, 0);
    chk("t6_valid", rdata_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ferr", frame_err, 0);
    chk("t6_ovf", overflow, 0);
`ifdef OLED_RX_OVF_CNT_EN
    chk("t6_ovf_count", ovf_count, 0);
`endif
    @(negedge sclk);
    cs = 1'b1;
    @(negedge sclk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    chk("t6_ferr_rel", frame_err, 0);
    send(8'h5A);
    chk("t6_rdata2", rdata, 8'h5A);
    chk("t6_valid2", rdata_valid, 1);
    step(1'b1, 1'b0);
    chk("t6_hold", rdata, 8'h5A);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
